// File: rtl/tdm_demux_rx.sv
// TDM link receiver: acquires frame alignment from the sync marker and splits the serial stream into NUM_CH words.
// Optional build macro TDM_DEMUX_PARITY_EN appends one even-parity bit to every slot.
module tdm_demux_rx #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       sync,
    input  logic                       sdata,
    output logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic [NUM_CH-1:0]          ch_valid,
    output logic                       locked,
    output logic                       sync_err,
    output logic                       par_err
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOT_W = DATA_W + 1;
`else
    localparam int SLOT_W = DATA_W;
`endif
    localparam int BW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    localparam int CW = $clog2(NUM_CH);

    typedef enum logic {HUNT, ALIGNED} state_t;
    state_t state;

    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     cur_bit;
    logic [CW-1:0]     ch_cnt;
    logic [CW-1:0]     cur_ch;
    logic [SLOT_W-1:0] shift_reg;
    logic [SLOT_W-1:0] shift_base;
    logic [SLOT_W-1:0] shift_next;
    logic [DATA_W-1:0] word;
    logic              par_ok;
    logic              boundary;
    logic              slot_last;

    // A sync bit always restarts the slot at ch0 bit 0, whatever the counters say.
    always_comb begin
        boundary   = (bit_cnt == '0) && (ch_cnt == '0);
        cur_bit    = sync ? '0 : bit_cnt;
        cur_ch     = sync ? '0 : ch_cnt;
        shift_base = sync ? '0 : shift_reg;
        shift_next = SLOT_W'({shift_base, sdata});
        slot_last  = (cur_bit == BW'(SLOT_W - 1));
`ifdef TDM_DEMUX_PARITY_EN
        word   = shift_next[SLOT_W-1 -: DATA_W];
        par_ok = ~^shift_next;
`else
        word   = shift_next;
        par_ok = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            bit_cnt   <= '0;
            ch_cnt    <= '0;
            shift_reg <= '0;
            ch_data   <= '0;
            ch_valid  <= '0;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            ch_valid <= '0;
            sync_err <= 1'b0;
            par_err  <= 1'b0;
            if (en && (state == ALIGNED || sync)) begin
                if (state == ALIGNED && boundary && !sync) begin
                    // Missing marker: drop alignment and discard this bit.
                    sync_err  <= 1'b1;
                    state     <= HUNT;
                    locked    <= 1'b0;
                    bit_cnt   <= '0;
                    ch_cnt    <= '0;
                    shift_reg <= '0;
                end else begin
                    if (state == ALIGNED && sync && !boundary)
                        sync_err <= 1'b1;
                    state  <= ALIGNED;
                    locked <= 1'b1;
                    if (slot_last) begin
                        bit_cnt   <= '0;
                        ch_cnt    <= (cur_ch == CW'(NUM_CH - 1)) ? '0 : cur_ch + CW'(1);
                        shift_reg <= '0;
                        if (par_ok) begin
                            for (int k = 0; k < NUM_CH; k++) begin
                                if (cur_ch == CW'(k)) begin
                                    ch_data[k*DATA_W +: DATA_W] <= word;
                                    ch_valid[k]                 <= 1'b1;
                                end
                            end
                        end else begin
                            par_err <= 1'b1;
                        end
                    end else begin
                        bit_cnt   <= cur_bit + BW'(1);
                        ch_cnt    <= cur_ch;
                        shift_reg <= shift_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Directed bench for tdm_demux_rx (NUM_CH=2, DATA_W=8): per-cycle vector table plus reset corner sequence.
module tb_tdm_demux_rx;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOT_W = 9;
`else
    localparam int SLOT_W = 8;
`endif

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sync;
    logic        sdata;
    logic [15:0] ch_data;
    logic [1:0]  ch_valid;
    logic        locked;
    logic        sync_err;
    logic        par_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic        sync;
        logic        sd;
        logic [15:0] data;
        logic [1:0]  vld;
        logic        lk;
        logic        serr;
        logic        perr;
    } vec_t;

    vec_t        tbl[$];
    logic [8:0]  exp_q[$];
    logic [15:0] exp_data;
    logic        exp_lock;

    tdm_demux_rx #(.NUM_CH(2), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync     (sync),
        .sdata    (sdata),
        .ch_data  (ch_data),
        .ch_valid (ch_valid),
        .locked   (locked),
        .sync_err (sync_err),
        .par_err  (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add_row(input logic e, input logic s, input logic d, input logic [1:0] v,
                           input logic se, input logic pe);
        vec_t r;
        r.en = e; r.sync = s; r.sd = d; r.data = exp_data; r.vld = v;
        r.lk = exp_lock; r.serr = se; r.perr = pe;
        tbl.push_back(r);
    endtask

    // Appends one slot starting at bit first_bit; gap adds an ignored en=0 cycle after every bit.
    task automatic add_slot(input logic [7:0] b, input int ch, input logic sync_first,
                            input logic bad_par, input int first_bit, input logic gap);
        logic       sd;
        logic       s;
        logic [1:0] v;
        logic       pe;
        logic [8:0] e;
        for (int i = first_bit; i < SLOT_W; i++) begin
            sd = (i < 8) ? b[7-i] : (^b ^ bad_par);
            s  = sync_first && (i == first_bit);
            if (s) exp_lock = 1'b1;
            v  = 2'b00;
            pe = 1'b0;
            if (i == SLOT_W - 1) begin
                if (bad_par) pe = 1'b1;
                else begin
                    exp_data[ch*8 +: 8] = b;
                    v[ch] = 1'b1;
                    e = {ch[0], b};
                    exp_q.push_back(e);
                end
            end
            add_row(1'b1, s, sd, v, 1'b0, pe);
            if (gap) add_row(1'b0, 1'b1, ~sd, 2'b00, 1'b0, 1'b0);
        end
    endtask

    task automatic apply_table(input string phase);
        vec_t r;
        for (int i = 0; i < tbl.size(); i++) begin
            r = tbl[i];
            @(negedge clk);
            en = r.en; sync = r.sync; sdata = r.sd;
            @(posedge clk);
            #1;
            checks++;
            if ({ch_data, ch_valid, locked, sync_err, par_err} !== {r.data, r.vld, r.lk, r.serr, r.perr}) begin
                errors++;
                $display("FAIL %s row %0d actual data=%h vld=%b lk=%b serr=%b perr=%b required data=%h vld=%b lk=%b serr=%b perr=%b",
                         phase, i, ch_data, ch_valid, locked, sync_err, par_err,
                         r.data, r.vld, r.lk, r.serr, r.perr);
            end
        end
        tbl.delete();
    endtask

    // Scoreboard: every observed valid strobe must match the next expected {channel, word}.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rst_n && ch_valid[k]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard unexpected valid ch=%0d data=%h", k, ch_data[k*8 +: 8]);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if ({k[0], ch_data[k*8 +: 8]} !== e) begin
                        errors++;
                        $display("FAIL scoreboard actual ch=%0d data=%h required ch=%0d data=%h",
                                 k, ch_data[k*8 +: 8], e[8], e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        rst_n = 1'b0; en = 1'b0; sync = 1'b0; sdata = 1'b0;
        exp_data = 16'h0000; exp_lock = 1'b0;
        #12;
        check("reset ch_data", 32'(ch_data), 32'h0);
        check("reset ch_valid", 32'(ch_valid), 32'h0);
        check("reset locked", 32'(locked), 32'h0);
        check("reset sync_err", 32'(sync_err), 32'h0);
        check("reset par_err", 32'(par_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hunting: data ignored without a marker.
        for (int i = 0; i < 3; i++) add_row(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        // Two aligned frames.
        add_slot(8'hA5, 0, 1'b1, 1'b0, 0, 1'b0);
        add_slot(8'h3C, 1, 1'b0, 1'b0, 0, 1'b0);
        add_slot(8'hA5, 0, 1'b1, 1'b0, 0, 1'b0);
        add_slot(8'h3C, 1, 1'b0, 1'b0, 0, 1'b0);
        // Same frame with en toggling every cycle.
        add_slot(8'hA5, 0, 1'b1, 1'b0, 0, 1'b1);
        add_slot(8'h3C, 1, 1'b0, 1'b0, 0, 1'b1);
        // Marker at bit 3 of ch1: partial slot dropped, realigned on that bit.
        add_slot(8'hA5, 0, 1'b1, 1'b0, 0, 1'b0);
        add_row(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        add_row(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        add_row(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        add_row(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        add_slot(8'h5A, 0, 1'b0, 1'b0, 1, 1'b0);
        add_slot(8'hC3, 1, 1'b0, 1'b0, 0, 1'b0);
        // Missing marker at the frame boundary: alignment lost.
        exp_lock = 1'b0;
        add_row(1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) add_row(1'b1, 1'b0, i[0], 2'b00, 1'b0, 1'b0);
        add_slot(8'h11, 0, 1'b1, 1'b0, 0, 1'b0);
        add_slot(8'h22, 1, 1'b0, 1'b0, 0, 1'b0);
        apply_table("stream");
        check("data before reset", 32'(ch_data), 32'h2211);

        // Asynchronous reset in the middle of ch0 (after bit 4).
        b = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en = 1'b1; sync = (i == 0); sdata = b[7-i];
            @(posedge clk);
            #1;
        end
        check("locked before reset", 32'(locked), 32'h1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset ch_data", 32'(ch_data), 32'h0);
        check("async reset ch_valid", 32'(ch_valid), 32'h0);
        check("async reset locked", 32'(locked), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        exp_data = 16'h0000; exp_lock = 1'b0;
        for (int i = 0; i < 12; i++) add_row(1'b1, 1'b0, ~i[0], 2'b00, 1'b0, 1'b0);
        add_slot(8'h77, 0, 1'b1, 1'b0, 0, 1'b0);
        add_slot(8'h88, 1, 1'b0, 1'b0, 0, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
        add_slot(8'hA5, 0, 1'b1, 1'b1, 0, 1'b0);
        add_slot(8'h3C, 1, 1'b0, 1'b0, 0, 1'b0);
`endif
        apply_table("after_reset");

        @(negedge clk);
        en = 1'b0; sync = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
